// File: rtl/data_sram_responder_if.sv
// rtl/data_sram_responder_if.sv - data-side SRAM load/store bus between EX/MEM stages and the responder.
// addr_err exists only when DSRAM_BOUNDS_CHECK_EN is defined.
interface data_sram_responder_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_mem;
`ifdef DSRAM_BOUNDS_CHECK_EN
  logic        addr_err;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, stallreq_mem, addr_err
  );
  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, stallreq_mem, addr_err
  );
`else
  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, stallreq_mem
  );
  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, stallreq_mem
  );
`endif
endinterface

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data SRAM responder with byte-enable writes, registered reads, optional wait states.
// Optional range checking and addr_err flag: DSRAM_BOUNDS_CHECK_EN.
module data_sram_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  data_sram_responder_if.slave  bus
);

  localparam int DEPTH    = 1 << DEPTH_LOG2;
  localparam int CNT_W    = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam int LOAD_INT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = LOAD_INT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [3:0]             cap_wen_q;
  logic [DEPTH_LOG2-1:0]  cap_idx_q;
  logic [31:0]            cap_wdata_q;
  logic                   cap_oob_q;

  logic [31:0]            mem [DEPTH];
  logic [31:0]            rdata_q;

  logic [DEPTH_LOG2-1:0]  live_idx;
  logic                   live_oob;
  logic                   accept;
  logic                   stall;
  logic                   do_access;
  logic                   use_cap;
  logic [3:0]             acc_wen;
  logic [DEPTH_LOG2-1:0]  acc_idx;
  logic [31:0]            acc_wdata;
  logic                   acc_oob;

  assign live_idx = bus.data_sram_addr[DEPTH_LOG2+1:2];

`ifdef DSRAM_BOUNDS_CHECK_EN
  logic err_q;
  logic unused_addr_bits;
  assign live_oob         = |bus.data_sram_addr[31:DEPTH_LOG2+2];
  assign unused_addr_bits = ^bus.data_sram_addr[1:0];
  assign bus.addr_err     = err_q;
`else
  logic unused_addr_bits;
  assign live_oob         = 1'b0;
  assign unused_addr_bits = ^{bus.data_sram_addr[31:DEPTH_LOG2+2], bus.data_sram_addr[1:0]};
`endif

  assign accept = (WAIT_CYCLES > 0) && (state_q == IDLE) && bus.data_sram_en && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts the BUSY cycles still to run, including the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (WAIT_CYCLES > 0) begin
      case (state_q)
        IDLE: begin
          if (bus.data_sram_en) begin
            cnt_d   = CNT_LOAD;
            state_d = (WAIT_CYCLES == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // DONE never stalls and never accepts: the pipeline is still presenting the finished request.
  always_comb begin
    stall     = 1'b0;
    do_access = 1'b0;
    use_cap   = 1'b0;
    if (WAIT_CYCLES == 0) begin
      do_access = bus.data_sram_en;
    end else begin
      case (state_q)
        IDLE: begin
          stall     = bus.data_sram_en;
          do_access = bus.data_sram_en && (WAIT_CYCLES == 1);
        end
        BUSY: begin
          stall     = 1'b1;
          use_cap   = 1'b1;
          do_access = (cnt_q == CNT_ONE);
        end
        default: ;
      endcase
    end
    if (rst) begin
      do_access = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_wen_q   <= bus.data_sram_wen;
      cap_idx_q   <= live_idx;
      cap_wdata_q <= bus.data_sram_wdata;
      cap_oob_q   <= live_oob;
    end
  end

  assign acc_wen   = use_cap ? cap_wen_q   : bus.data_sram_wen;
  assign acc_idx   = use_cap ? cap_idx_q   : live_idx;
  assign acc_wdata = use_cap ? cap_wdata_q : bus.data_sram_wdata;
  assign acc_oob   = use_cap ? cap_oob_q   : live_oob;

  always_ff @(posedge clk) begin
    if (do_access && (acc_wen != 4'h0) && !acc_oob) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wen[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (do_access && (acc_wen == 4'h0)) begin
      rdata_q <= acc_oob ? 32'h0 : mem[acc_idx];
    end
  end

`ifdef DSRAM_BOUNDS_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (do_access) begin
      err_q <= acc_oob;
    end
  end
`endif

  assign bus.data_sram_rdata = rdata_q;
  assign bus.stallreq_mem    = stall;

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Data-side SRAM responder: the memory end of the load/store interface driven by the EX stage and consumed by the MEM stage.
- Accepts a request in the EX cycle: word write with byte enables, or read. Returns read data registered, so it is valid in the following MEM cycle.
- Optional wait states are reported through a stall request toward the pipeline controller. Used as the simulation and FPGA data memory.

Parameters:
DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (1024 words).
WAIT_CYCLES, 0, extra access latency in cycles; 0 = single-cycle SRAM behaviour.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
data_sram_en  in  1  request valid
data_sram_wen  in  4  byte write enables; nonzero = write, zero = read
data_sram_addr  in  32  byte address
data_sram_wdata  in  32  write data; byte i in bits [8i+7:8i]
data_sram_rdata  out  32  registered read data
stallreq_mem  out  1  stall request to the controller while an access is pending
addr_err  out  1  present only with DSRAM_BOUNDS_CHECK_EN

Behaviour:
- Word index = data_sram_addr[DEPTH_LOG2+1:2]. Bits [1:0] are ignored.
- Without the optional feature, bits above DEPTH_LOG2+1 are ignored and addresses alias.
- Write: each byte i with wen[i]=1 is updated. Other bytes are unchanged.
- Write does not modify data_sram_rdata.
- Read: the full word is loaded into data_sram_rdata. rdata holds its value until the next read completes.
- Reset values: data_sram_rdata=0, stallreq_mem=0, addr_err=0, FSM=IDLE. Array contents are not cleared.
- WAIT_CYCLES=0:
  - No FSM activity. stallreq_mem is constantly 0.
  - A request in cycle t is performed at the clock edge ending cycle t.
  - For a read, rdata is valid from cycle t+1.
  - Back-to-back requests every cycle are allowed. A write to A in cycle t followed by a read of A in cycle t+1 returns the new data.
- WAIT_CYCLES=W>0, FSM IDLE -> BUSY -> DONE:
  - IDLE with en=1:
    - Request is captured (wen, index, wdata) and counter loaded with W-1.
    - stallreq_mem=1 combinationally in this cycle t.
    - If W=1, go directly to DONE after performing the access at the end of t. Otherwise go to BUSY.
  - BUSY:
    - stallreq_mem=1. Counter decrements each cycle.
    - When the counter reaches 0, the captured access is performed at the end of that cycle (t+W-1) and the FSM goes to DONE.
    - Live inputs are ignored in BUSY; the captured copy is used.
  - DONE:
    - stallreq_mem=0. The pipeline advances this cycle while the completed request is still presented, so en is ignored here (no duplicate access).
    - Return to IDLE.
    - A new request is accepted no earlier than cycle t+W+1. Read data is valid from cycle t+W.
  - IDLE with en=0: stallreq_mem=0, no state change.
- Reset mid-operation (BUSY or DONE): go to IDLE and drop stallreq_mem. A pending write that has not been performed is discarded. rdata=0.

Optional Feature:
- Macro: DSRAM_BOUNDS_CHECK_EN.
- Defined:
  - addr_err port exists.
  - A request whose addr[31:DEPTH_LOG2+2] is nonzero is out of range. Such a write is suppressed; such a read loads 0 into rdata.
  - addr_err is a registered flag, updated in the same cycle the access is performed: 1 for an out-of-range access, 0 for an in-range one. It holds between accesses and resets to 0.
- Not defined: no addr_err port, no range check, and upper address bits alias as described.

Test Plan:
- W=0: write 0xDEADBEEF to 0x10 with wen=4'hF, then read 0x10 next cycle -> rdata=0xDEADBEEF in the cycle after the read; stallreq_mem stays 0.
- W=0 byte lanes: write 0x11223344 (wen=F), then 0xAABBCCDD with wen=4'b0101, then read -> 0x11BB33DD.
- W=3: read of 0x20 holding 0x5A5A5A5A at cycle t -> stallreq_mem=1 in t..t+2 and 0 at t+3; rdata=0x5A5A5A5A from t+3; en still high at t+3 causes no second access.
- W=2: write 0x12345678 to 0x40, rst asserted during BUSY -> stall drops next cycle; a subsequent read of 0x40 returns the old contents.
- W=0: read of 0x8 with stored 0x77, followed by 5 idle cycles and a write to 0xC -> rdata stays 0x77 throughout.
- DSRAM_BOUNDS_CHECK_EN, DEPTH_LOG2=10: write 0xFFFFFFFF to 0x1000 (index 0 aliased), then read 0x0 -> old value returned; addr_err=1 after the write and 0 after the read.
